// File: rtl/spike_pkg.sv
// Spike packet field layout shared by the controller-side packet builder and the local-port receiver.
package spike_pkg;
    localparam int PACKET_WIDTH = 32;
    localparam int DST_X_MSB    = 31;
    localparam int DST_X_LSB    = 28;
    localparam int DST_Y_MSB    = 27;
    localparam int DST_Y_LSB    = 24;
    localparam int STEP_MSB     = 23;
    localparam int STEP_LSB     = 16;
    localparam int AXON_MSB     = 15;
    localparam int AXON_LSB     = 0;

    function automatic logic [PACKET_WIDTH-1:0] make_packet(
        input logic [DST_X_MSB-DST_X_LSB:0] dst_x,
        input logic [DST_Y_MSB-DST_Y_LSB:0] dst_y,
        input logic [STEP_MSB-STEP_LSB:0]   step,
        input logic [AXON_MSB-AXON_LSB:0]   axon
    );
        return {dst_x, dst_y, step, axon};
    endfunction
endpackage

// File: rtl/spike_fifo.sv
// Synchronous packet FIFO with registered occupancy count; pushes are refused while full.
module spike_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     data_in,
    output logic [WIDTH-1:0]     head,
    output logic [PTR_WIDTH:0]   count,
    output logic                 full,
    output logic                 empty
);
    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == (PTR_WIDTH+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end
endmodule

// File: rtl/spike_packet_receiver.sv
// Local-port spike sink: buffers router packets, drops misrouted ones, presents axon spikes
// to the neuron core on valid/ready. spike_valid may only fall after a cycle with spike_ready high.
module spike_packet_receiver
    import spike_pkg::*;
#(
    parameter int NODE_X             = 0,
    parameter int NODE_Y             = 0,
    parameter int NUM_AXONS          = 2,
    parameter int AXON_CNT_BIT_WIDTH = 1,
    parameter int FIFO_DEPTH         = 4,
    parameter int FIFO_PTR_WIDTH     = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PACKET_WIDTH-1:0]       packet_in,
    input  logic                          write_enable,
    output logic                          receive_full,
    output logic                          spike_valid,
    input  logic                          spike_ready,
    output logic [AXON_CNT_BIT_WIDTH-1:0] axon_id,
    output logic [7:0]                    spike_step,
    input  logic                          step_clear,
    output logic [15:0]                   spike_count,
    output logic [7:0]                    drop_count,
    output logic                          overflow
);
    localparam logic [DST_X_MSB-DST_X_LSB:0] NODE_X_F   = (DST_X_MSB-DST_X_LSB+1)'(NODE_X);
    localparam logic [DST_Y_MSB-DST_Y_LSB:0] NODE_Y_F   = (DST_Y_MSB-DST_Y_LSB+1)'(NODE_Y);
    localparam logic [AXON_MSB-AXON_LSB+1:0] AXON_LIMIT = (AXON_MSB-AXON_LSB+2)'(NUM_AXONS);

    logic [PACKET_WIDTH-1:0]   head;
    logic [FIFO_PTR_WIDTH:0]   fifo_count;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      head_good;
    logic                      misroute;
    logic                      delivered;
    logic                      push;
    logic                      pop;
    logic                      overflow_evt;
    logic [1:0]                drop_inc;
    logic [8:0]                drop_sum;

    spike_fifo #(
        .WIDTH     (PACKET_WIDTH),
        .DEPTH     (FIFO_DEPTH),
        .PTR_WIDTH (FIFO_PTR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .data_in (packet_in),
        .head    (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Full-width axon compare also rejects any nonzero bits above the axon_id width.
    assign head_good = (head[DST_X_MSB:DST_X_LSB] == NODE_X_F)
                    && (head[DST_Y_MSB:DST_Y_LSB] == NODE_Y_F)
                    && ({1'b0, head[AXON_MSB:AXON_LSB]} < AXON_LIMIT);

    assign receive_full = (fifo_count == (FIFO_PTR_WIDTH+1)'(FIFO_DEPTH));
    assign spike_valid  = !fifo_empty && head_good;
    assign misroute     = !fifo_empty && !head_good;
    assign delivered    = spike_valid && spike_ready;
    assign pop          = misroute || delivered;
    assign push         = write_enable && !fifo_full;
    assign overflow_evt = write_enable && fifo_full;
    assign axon_id      = spike_valid ? head[AXON_LSB +: AXON_CNT_BIT_WIDTH] : '0;
    assign spike_step   = spike_valid ? head[STEP_MSB:STEP_LSB] : '0;

    assign drop_inc = {1'b0, overflow_evt} + {1'b0, misroute};
    assign drop_sum = {1'b0, drop_count} + {7'b0, drop_inc};

    always_ff @(posedge clk) begin
        if (reset) begin
            spike_count <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
        end else begin
            if (overflow_evt) overflow <= 1'b1;

            if (step_clear)
                spike_count <= '0;
            else if (delivered && spike_count != 16'hFFFF)
                spike_count <= spike_count + 1'b1;

            if (step_clear)
                drop_count <= '0;
            else if (drop_sum[8])
                drop_count <= 8'hFF;
            else
                drop_count <= drop_sum[7:0];
        end
    end
endmodule

// File: tb/tb_spike_packet_receiver.sv
// Directed bench for spike_packet_receiver at NODE (0,0), 2 axons, 4-entry FIFO.
module tb_spike_packet_receiver;
    import spike_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] packet_in;
    logic        write_enable;
    logic        receive_full;
    logic        spike_valid;
    logic        spike_ready;
    logic [0:0]  axon_id;
    logic [7:0]  spike_step;
    logic        step_clear;
    logic [15:0] spike_count;
    logic [7:0]  drop_count;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    spike_packet_receiver #(
        .NODE_X             (0),
        .NODE_Y             (0),
        .NUM_AXONS          (2),
        .AXON_CNT_BIT_WIDTH (1),
        .FIFO_DEPTH         (4),
        .FIFO_PTR_WIDTH     (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .packet_in    (packet_in),
        .write_enable (write_enable),
        .receive_full (receive_full),
        .spike_valid  (spike_valid),
        .spike_ready  (spike_ready),
        .axon_id      (axon_id),
        .spike_step   (spike_step),
        .step_clear   (step_clear),
        .spike_count  (spike_count),
        .drop_count   (drop_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] pkt;
        logic        rdy;
        logic        clr;
        logic        e_valid;
        logic [0:0]  e_axon;
        logic [7:0]  e_step;
        logic        e_full;
        logic [15:0] e_sc;
        logic [7:0]  e_dc;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[23];
    logic [8:0] exp_q[$];

    function automatic vec_t v(input logic we, input logic [31:0] pkt, input logic rdy,
                               input logic clr, input logic e_valid, input logic [0:0] e_axon,
                               input logic [7:0] e_step, input logic e_full,
                               input logic [15:0] e_sc, input logic [7:0] e_dc,
                               input logic e_ovf);
        vec_t r;
        r.we = we; r.pkt = pkt; r.rdy = rdy; r.clr = clr;
        r.e_valid = e_valid; r.e_axon = e_axon; r.e_step = e_step; r.e_full = e_full;
        r.e_sc = e_sc; r.e_dc = e_dc; r.e_ovf = e_ovf;
        return r;
    endfunction

    function automatic logic [31:0] pk(input int x, input int y, input int s, input int a);
        return make_packet(4'(x), 4'(y), 8'(s), 16'(a));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] pkt, input logic rdy, input logic clr);
        write_enable = we;
        packet_in    = pkt;
        spike_ready  = rdy;
        step_clear   = clr;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " valid"}, 32'(spike_valid), 0);
        check({tag, " full"},  32'(receive_full), 0);
        check({tag, " axon"},  32'(axon_id), 0);
        check({tag, " step"},  32'(spike_step), 0);
        check({tag, " sc"},    32'(spike_count), 0);
        check({tag, " dc"},    32'(drop_count), 0);
        check({tag, " ovf"},   32'(overflow), 0);
    endtask

    initial begin
        // Each row: inputs for the cycle, outputs observed before the closing edge.
        //               we  pkt              rdy clr  val ax step  full sc  dc ovf
        vecs[0]  = v(1, pk(0,0,5,1),   0, 0,  0, 0, 0,   0, 0, 0, 0);
        vecs[1]  = v(0, 0,             1, 0,  1, 1, 5,   0, 0, 0, 0);
        vecs[2]  = v(0, 0,             1, 0,  0, 0, 0,   0, 1, 0, 0);
        vecs[3]  = v(1, pk(1,0,7,0),   1, 0,  0, 0, 0,   0, 1, 0, 0);
        vecs[4]  = v(1, pk(0,0,8,0),   1, 0,  0, 0, 0,   0, 1, 0, 0);
        vecs[5]  = v(0, 0,             1, 0,  1, 0, 8,   0, 1, 1, 0);
        vecs[6]  = v(0, 0,             1, 0,  0, 0, 0,   0, 2, 1, 0);
        vecs[7]  = v(1, pk(0,0,9,2),   1, 0,  0, 0, 0,   0, 2, 1, 0);
        vecs[8]  = v(0, 0,             1, 0,  0, 0, 0,   0, 2, 1, 0);
        vecs[9]  = v(0, 0,             1, 0,  0, 0, 0,   0, 2, 2, 0);
        vecs[10] = v(1, pk(0,0,10,0),  0, 0,  0, 0, 0,   0, 2, 2, 0);
        vecs[11] = v(1, pk(0,0,11,1),  0, 0,  1, 0, 10,  0, 2, 2, 0);
        vecs[12] = v(1, pk(0,0,12,0),  0, 0,  1, 0, 10,  0, 2, 2, 0);
        vecs[13] = v(1, pk(0,0,13,1),  0, 0,  1, 0, 10,  0, 2, 2, 0);
        vecs[14] = v(1, pk(0,0,14,0),  0, 0,  1, 0, 10,  1, 2, 2, 0);
        vecs[15] = v(0, 0,             1, 0,  1, 0, 10,  1, 2, 3, 1);
        vecs[16] = v(0, 0,             1, 0,  1, 1, 11,  0, 3, 3, 1);
        vecs[17] = v(0, 0,             1, 0,  1, 0, 12,  0, 4, 3, 1);
        vecs[18] = v(0, 0,             1, 0,  1, 1, 13,  0, 5, 3, 1);
        vecs[19] = v(0, 0,             1, 0,  0, 0, 0,   0, 6, 3, 1);
        vecs[20] = v(1, pk(0,0,20,1),  1, 0,  0, 0, 0,   0, 6, 3, 1);
        vecs[21] = v(0, 0,             1, 1,  1, 1, 20,  0, 6, 3, 1);
        vecs[22] = v(0, 0,             1, 0,  0, 0, 0,   0, 0, 0, 1);

        reset = 1'b1;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_values("reset");

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].we, vecs[i].pkt, vecs[i].rdy, vecs[i].clr);
            #1;
            check($sformatf("v%0d valid", i), 32'(spike_valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d axon", i), 32'(axon_id), 32'(vecs[i].e_axon));
                check($sformatf("v%0d step", i), 32'(spike_step), 32'(vecs[i].e_step));
            end
            check($sformatf("v%0d full", i), 32'(receive_full), 32'(vecs[i].e_full));
            check($sformatf("v%0d sc", i),   32'(spike_count), 32'(vecs[i].e_sc));
            check($sformatf("v%0d dc", i),   32'(drop_count), 32'(vecs[i].e_dc));
            check($sformatf("v%0d ovf", i),  32'(overflow), 32'(vecs[i].e_ovf));
            @(posedge clk);
            #1;
        end

        // Streaming: prefill two, then push and pop every cycle for 100 packets.
        for (int i = 0; i < 102; i++) begin
            drive(1, pk(0, 0, i, i % 2), (i >= 2), 0);
            #1;
            if (i >= 2) begin
                check($sformatf("stream%0d valid", i), 32'(spike_valid), 1);
                check($sformatf("stream%0d full", i), 32'(receive_full), 0);
            end
            if (spike_valid && spike_ready) begin
                if (exp_q.size() == 0) check("stream unexpected spike", 32'({axon_id, spike_step}), 0);
                else check($sformatf("stream%0d data", i), 32'({axon_id, spike_step}), 32'(exp_q.pop_front()));
            end
            if (write_enable && !receive_full) exp_q.push_back({1'(i % 2), 8'(i)});
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            drive(0, 0, 1, 0);
            #1;
            if (spike_valid) check($sformatf("drain%0d data", c), 32'({axon_id, spike_step}), 32'(exp_q.pop_front()));
            @(posedge clk);
            #1;
        end
        check("stream leftover", 32'(exp_q.size()), 0);
        drive(0, 0, 1, 0);
        #1;
        check("stream sc", 32'(spike_count), 102);
        check("stream dc", 32'(drop_count), 0);
        check("stream idle valid", 32'(spike_valid), 0);

        // Reset mid-stream with a full FIFO and overflow set.
        for (int i = 0; i < 5; i++) begin
            drive(1, pk(0, 0, 40 + i, 1), 0, 0);
            tick();
        end
        check("pre-reset ovf", 32'(overflow), 1);
        check("pre-reset full", 32'(receive_full), 1);
        reset = 1'b1;
        drive(1, pk(0, 0, 50, 1), 0, 0);
        tick();
        reset = 1'b0;
        drive(0, 0, 1, 0);
        #1;
        check_reset_values("midreset");
        tick();
        check("post-reset valid", 32'(spike_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
